// File: rtl/lbdr_route_ctrl.sv
// lbdr_route_ctrl
//   Minimal LBDR routing controller for one input port of a 2D-mesh NoC
//   router. A HEADER flit's destination is compared against the local node
//   address. The result is reduced to a single one-hot output-port request,
//   which is held until the packet's TAIL is granted. Routing bits,
//   connectivity bits and the local address live in runtime-writable
//   registers. These registers reset to the parameter values and otherwise
//   change only on cfg_we_i.
//
//   Optional feature macro: LBDR_DEROUTE_EN
//     When defined, a header with no minimal candidate goes to the port
//     selected by cfg_dr, provided that port is connected. When undefined,
//     cfg_dr_i is accepted but ignored, and every unroutable header
//     raises route_err_o.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   cfg_we_i     load cfg_* into the config registers
//   cfg_rxy_i    routing bits {Rsw,Rse,Rws,Rwn,Res,Ren,Rnw,Rne}
//   cfg_cx_i     connectivity bits {Cs,Cw,Ce,Cn}
//   cfg_addr_i   local node address {y,x}
//   cfg_dr_i     deroute port select 0=N 1=E 2=W 3=S
//   empty_i      input FIFO empty (flit_id_i/dst_addr_i invalid)
//   flit_id_i    flit type (`HEADER/`PAYLOAD/`TAIL)
//   dst_addr_i   destination {y,x}, used on HEADER only
//   grant_i      downstream accepted the current flit
//   req_valid_o  route held, req_port_o valid
//   req_port_o   one-hot {L,S,W,E,N}
//   route_err_o  one-cycle pulse on unroutable header or protocol violation
//
// State | meaning
//   IDLE   | no route held, waiting for a HEADER
//   ACTIVE | route held until a granted TAIL

`ifndef HEADER
`define HEADER 3'b001
`endif
`ifndef PAYLOAD
`define PAYLOAD 3'b010
`endif
`ifndef TAIL
`define TAIL 3'b100
`endif

module lbdr_route_ctrl #(
  parameter int unsigned X_W       = 2,
  parameter int unsigned Y_W       = 2,
  parameter logic [7:0]  RXY_INIT  = 8'd60,
  parameter logic [3:0]  CX_INIT   = 4'd15,
  parameter int unsigned ADDR_INIT = 5,
  parameter bit          XY_FIRST  = 1'b1,
  localparam int unsigned ADDR_W   = X_W + Y_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cfg_we_i,
  input  logic [7:0]        cfg_rxy_i,
  input  logic [3:0]        cfg_cx_i,
  input  logic [ADDR_W-1:0] cfg_addr_i,
  input  logic [1:0]        cfg_dr_i,
  input  logic              empty_i,
  input  logic [2:0]        flit_id_i,
  input  logic [ADDR_W-1:0] dst_addr_i,
  input  logic              grant_i,
  output logic              req_valid_o,
  output logic [4:0]        req_port_o,
  output logic              route_err_o
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [4:0]        req_port_q, req_port_d;
  logic              route_err_q, route_err_d;
  logic [7:0]        rxy_q;
  logic [3:0]        cx_q;
  logic [ADDR_W-1:0] addr_q;

  logic [X_W-1:0] x_cur, x_dst;
  logic [Y_W-1:0] y_cur, y_dst;
  logic n1, s1, e1, w1;
  logic cand_n, cand_e, cand_w, cand_s, cand_l;
  logic [4:0] sel;

  assign x_cur = addr_q[X_W-1:0];
  assign y_cur = addr_q[ADDR_W-1:X_W];
  assign x_dst = dst_addr_i[X_W-1:0];
  assign y_dst = dst_addr_i[ADDR_W-1:X_W];

  assign n1 = y_dst < y_cur;
  assign s1 = y_cur < y_dst;
  assign e1 = x_cur < x_dst;
  assign w1 = x_dst < x_cur;

  // rxy_q bit order: 0 Rne, 1 Rnw, 2 Ren, 3 Res, 4 Rwn, 5 Rws, 6 Rse, 7 Rsw
  assign cand_n = n1 & ((~e1 & ~w1) | (e1 & rxy_q[0]) | (w1 & rxy_q[1])) & cx_q[0];
  assign cand_e = e1 & ((~n1 & ~s1) | (n1 & rxy_q[2]) | (s1 & rxy_q[3])) & cx_q[1];
  assign cand_w = w1 & ((~n1 & ~s1) | (n1 & rxy_q[4]) | (s1 & rxy_q[5])) & cx_q[2];
  assign cand_s = s1 & ((~e1 & ~w1) | (e1 & rxy_q[6]) | (w1 & rxy_q[7])) & cx_q[3];
  assign cand_l = ~n1 & ~e1 & ~w1 & ~s1;

`ifdef LBDR_DEROUTE_EN
  logic [1:0] dr_q;
`else
  logic unused_cfg_dr;
  assign unused_cfg_dr = ^cfg_dr_i;
`endif

  // Reduce the candidate set to one port; bit order is {L,S,W,E,N}
  always_comb begin
    sel = '0;
    if (cand_l) begin
      sel = 5'b10000;
    end else if (XY_FIRST) begin
      if      (cand_e) sel = 5'b00010;
      else if (cand_w) sel = 5'b00100;
      else if (cand_n) sel = 5'b00001;
      else if (cand_s) sel = 5'b01000;
    end else begin
      if      (cand_n) sel = 5'b00001;
      else if (cand_s) sel = 5'b01000;
      else if (cand_e) sel = 5'b00010;
      else if (cand_w) sel = 5'b00100;
    end
`ifdef LBDR_DEROUTE_EN
    // The encodings of dr_q and cx_q line up (0=N 1=E 2=W 3=S).
    // The deroute port's request bit is therefore 1 << dr_q.
    if ((sel == 5'b00000) && cx_q[dr_q]) sel = 5'b00001 << dr_q;
`endif
  end

  always_comb begin
    state_d     = state_q;
    req_port_d  = req_port_q;
    route_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty_i) begin
          if (flit_id_i == `HEADER) begin
            if (sel != 5'b00000) begin
              state_d    = ACTIVE;
              req_port_d = sel;
            end else begin
              route_err_d = 1'b1;
            end
          end else begin
            route_err_d = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (!empty_i) begin
          if (flit_id_i == `HEADER) begin
            route_err_d = 1'b1;
          end else if ((flit_id_i == `TAIL) && grant_i) begin
            state_d    = IDLE;
            req_port_d = '0;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        req_port_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      req_port_q  <= '0;
      route_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_port_q  <= req_port_d;
      route_err_q <= route_err_d;
    end
  end

  // Config registers are written in any state. They are sampled only when
  // a HEADER is routed, so a held route never changes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rxy_q  <= RXY_INIT;
      cx_q   <= CX_INIT;
      addr_q <= ADDR_W'(ADDR_INIT);
    end else if (cfg_we_i) begin
      rxy_q  <= cfg_rxy_i;
      cx_q   <= cfg_cx_i;
      addr_q <= cfg_addr_i;
    end
  end

`ifdef LBDR_DEROUTE_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)         dr_q <= 2'd0;
    else if (cfg_we_i) dr_q <= cfg_dr_i;
  end
`endif

  assign req_valid_o = (state_q == ACTIVE);
  assign req_port_o  = req_port_q;
  assign route_err_o = route_err_q;

endmodule

// File: tb/tb_lbdr_route_ctrl.sv
`ifndef HEADER
`define HEADER 3'b001
`endif
`ifndef PAYLOAD
`define PAYLOAD 3'b010
`endif
`ifndef TAIL
`define TAIL 3'b100
`endif

module tb_lbdr_route_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we;
  logic [7:0] cfg_rxy;
  logic [3:0] cfg_cx;
  logic [3:0] cfg_addr;
  logic [1:0] cfg_dr;
  logic       empty;
  logic [2:0] flit_id;
  logic [3:0] dst_addr;
  logic       grant;

  logic       va, ea, vb, eb;
  logic [4:0] pa, pb;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lbdr_route_ctrl dut_a (
    .clk_i(clk), .rst_i(rst), .cfg_we_i(cfg_we), .cfg_rxy_i(cfg_rxy),
    .cfg_cx_i(cfg_cx), .cfg_addr_i(cfg_addr), .cfg_dr_i(cfg_dr),
    .empty_i(empty), .flit_id_i(flit_id), .dst_addr_i(dst_addr),
    .grant_i(grant), .req_valid_o(va), .req_port_o(pa), .route_err_o(ea)
  );

  lbdr_route_ctrl #(.XY_FIRST(1'b0)) dut_b (
    .clk_i(clk), .rst_i(rst), .cfg_we_i(cfg_we), .cfg_rxy_i(cfg_rxy),
    .cfg_cx_i(cfg_cx), .cfg_addr_i(cfg_addr), .cfg_dr_i(cfg_dr),
    .empty_i(empty), .flit_id_i(flit_id), .dst_addr_i(dst_addr),
    .grant_i(grant), .req_valid_o(vb), .req_port_o(pb), .route_err_o(eb)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] f, input logic [3:0] d, input logic g);
    empty = 1'b0; flit_id = f; dst_addr = d; grant = g;
    step();
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_rxy = 8'd60; cfg_cx = 4'd15; cfg_addr = 4'd5;
    cfg_dr = 2'd0; empty = 1'b1; flit_id = 3'd0; dst_addr = 4'd0; grant = 1'b0;
    #12;
    chk("rst_valid", {7'd0, va}, 8'd0);
    chk("rst_port",  {3'd0, pa}, 8'd0);
    chk("rst_err",   {7'd0, ea}, 8'd0);
    step();
    rst = 1'b0;

    // empty FIFO: header-looking flit must be ignored
    empty = 1'b1; flit_id = `HEADER; dst_addr = 4'd15; step();
    chk("empty_idle_valid", {7'd0, va}, 8'd0);
    chk("empty_idle_err",   {7'd0, ea}, 8'd0);

    // default config, (1,1)->(3,3): E only (Res=1, Rse=0)
    send(`HEADER, 4'd15, 1'b0);
    chk("hdr_e_valid", {7'd0, va}, 8'd1);
    chk("hdr_e_port",  {3'd0, pa}, 8'b00010);
    chk("xy0_def_port", {3'd0, pb}, 8'b00010);
    repeat (3) send(`PAYLOAD, 4'd15, 1'b1);
    chk("pay_valid", {7'd0, va}, 8'd1);
    chk("pay_port",  {3'd0, pa}, 8'b00010);
    send(`TAIL, 4'd15, 1'b1);
    chk("tail_valid", {7'd0, va}, 8'd0);
    chk("tail_port",  {3'd0, pa}, 8'd0);

    // Rse=1: both E and S are candidates; tie-break differs per instance
    empty = 1'b1; cfg_we = 1'b1; cfg_rxy = 8'd124; step(); cfg_we = 1'b0;
    send(`HEADER, 4'd15, 1'b0);
    chk("xy1_port",   {3'd0, pa}, 8'b00010);
    chk("xy0_s_port", {3'd0, pb}, 8'b01000);
    send(`TAIL, 4'd15, 1'b0);
    chk("tail_nogrant_hold", {7'd0, va}, 8'd1);
    empty = 1'b1; flit_id = `TAIL; grant = 1'b1; step();
    chk("empty_hold_valid", {7'd0, va}, 8'd1);
    chk("empty_hold_port",  {3'd0, pa}, 8'b00010);
    send(`TAIL, 4'd15, 1'b1);
    chk("tail2_valid", {7'd0, va}, 8'd0);

    // cfg write (Res=0, Rse=1) on the same edge as a HEADER: old config routes
    cfg_we = 1'b1; cfg_rxy = 8'd116;
    send(`HEADER, 4'd15, 1'b0);
    cfg_we = 1'b0;
    chk("cfg_same_edge_old", {3'd0, pa}, 8'b00010);
    send(`TAIL, 4'd15, 1'b1);
    send(`HEADER, 4'd15, 1'b0);
    chk("cfg_new_applies", {3'd0, pa}, 8'b01000);
    send(`TAIL, 4'd15, 1'b1);

    // local delivery, plus a HEADER while ACTIVE
    send(`HEADER, 4'd5, 1'b0);
    chk("local_port", {3'd0, pa}, 8'b10000);
    send(`HEADER, 4'd15, 1'b0);
    chk("hdr_active_err",   {7'd0, ea}, 8'd1);
    chk("hdr_active_port",  {3'd0, pa}, 8'b10000);
    chk("hdr_active_valid", {7'd0, va}, 8'd1);
    send(`PAYLOAD, 4'd5, 1'b1);
    chk("err_pulse_end", {7'd0, ea}, 8'd0);
    repeat (2) send(`PAYLOAD, 4'd5, 1'b1);
    send(`TAIL, 4'd5, 1'b1);
    chk("local_tail_valid", {7'd0, va}, 8'd0);

    // PAYLOAD in IDLE is a protocol violation
    send(`PAYLOAD, 4'd5, 1'b1);
    chk("idle_payload_err",   {7'd0, ea}, 8'd1);
    chk("idle_payload_valid", {7'd0, va}, 8'd0);
    empty = 1'b1; step();
    chk("err_one_cycle", {7'd0, ea}, 8'd0);

    // Ce=0, pure-east destination (1,3): no minimal candidate
    cfg_we = 1'b1; cfg_cx = 4'b1101; cfg_dr = 2'd0; step(); cfg_we = 1'b0;
    send(`HEADER, 4'd7, 1'b0);
`ifdef LBDR_DEROUTE_EN
    chk("deroute_valid", {7'd0, va}, 8'd1);
    chk("deroute_port",  {3'd0, pa}, 8'b00001);
    chk("deroute_err",   {7'd0, ea}, 8'd0);
    send(`TAIL, 4'd7, 1'b1);
`else
    chk("unroute_err",   {7'd0, ea}, 8'd1);
    chk("unroute_valid", {7'd0, va}, 8'd0);
    chk("unroute_port",  {3'd0, pa}, 8'd0);
    chk("unroute_err_b", {7'd0, eb}, 8'd1);
`endif
    empty = 1'b1; step();

    // asynchronous reset in the middle of a packet
    send(`HEADER, 4'd5, 1'b0);
    send(`PAYLOAD, 4'd5, 1'b1);
    chk("pre_rst_valid", {7'd0, va}, 8'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", {7'd0, va}, 8'd0);
    chk("async_rst_port",  {3'd0, pa}, 8'd0);
    empty = 1'b1; step();
    rst = 1'b0;

    // config registers back to defaults (Ce=1, Res=1): E again
    send(`HEADER, 4'd15, 1'b0);
    chk("post_rst_port", {3'd0, pa}, 8'b00010);
    chk("post_rst_err",  {7'd0, ea}, 8'd0);
    send(`TAIL, 4'd15, 1'b1);
    empty = 1'b1; step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
